sram_rr_arbiter: RTL
====================

SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

Interface
REQ-001 SHALL have parameters: DW, default 8, data width; AW, default 19, address width; NCH, default 4, channel count (1..8); RD_LAT, default 1, SRAM read latency in cycles (1..4).
REQ-002 SHALL have ports, in order:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ch_en  in  NCH  per-channel request
- ch_we  in  NCH  per-channel write enable (1 = write, 0 = read)
- ch_addr  in  NCH*AW  per-channel address, channel i at [i*AW +: AW]
- ch_wdata  in  NCH*DW  per-channel write data
- ch_busy  out  NCH  request not accepted this cycle
- ch_rvalid  out  NCH  one-cycle read-data pulse
- ch_rdata  out  DW  read data, shared by all channels
- sram_addr  out  AW  PHY address
- sram_ce_n  out  1  chip enable, active low
- sram_we_n  out  1  write enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_dq_wr  out  DW  write data
- sram_dq_oe  out  1  drive sram_dq_wr onto the pad (tristate joined in top level)
- sram_dq_rd  in  DW  pad read data
REQ-003 SHALL use one clock, clk; reset is asynchronous and active-low on rst_n.

Function
REQ-004 SHALL grant at most one channel per cycle; channel i is accepted in cycle T when ch_en[i]=1 and ch_busy[i]=0.
REQ-005 SHALL drive ch_busy[i] combinationally: 1 when ch_en[i]=1 and channel i is not granted in that cycle; 0 when ch_en[i]=0.
REQ-006 SHALL arbitrate round-robin: search starts at pointer p; after a grant to channel g, p = (g+1) mod NCH; p does not change on idle cycles.
REQ-007 SHALL register the accepted request to the PHY in cycle T+1: sram_ce_n=0, sram_addr=ch_addr[g], and sram_we_n = !ch_we[g].
REQ-008 SHALL set, in the T+1 PHY cycle, sram_oe_n=0 and sram_dq_oe=0 for a read, and sram_oe_n=1, sram_dq_oe=1 and sram_dq_wr=ch_wdata[g] for a write.
REQ-009 SHALL drive sram_ce_n=1, sram_we_n=1, sram_oe_n=1 and sram_dq_oe=0 in every PHY cycle that has no accepted request.
REQ-010 SHALL track each read in a RD_LAT-deep pipeline of {valid, channel id}, sample sram_dq_rd on the clk edge that ends cycle T+RD_LAT, and present it in cycle T+1+RD_LAT as ch_rdata with ch_rvalid[g]=1 for exactly one cycle.
REQ-011 SHALL accept back-to-back requests every cycle; read data SHALL return in issue order, and one channel's ch_rvalid SHALL never be attributed to another channel.
REQ-012 SHALL produce no ch_rvalid pulse for writes; ch_rdata holds its last value when no ch_rvalid bit is set.
REQ-013 SHALL, with NCH=1, grant the single channel whenever ch_en=1, so that ch_busy is constantly 0.

Reset
REQ-014 SHALL, while rst_n=0: sram_ce_n=1, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_wr=0, ch_rvalid=0, ch_rdata=0, p=0, and all read-pipeline valid bits cleared.
REQ-015 SHALL discard reads in flight when reset is asserted mid-operation, so that no ch_rvalid is produced for them after release.

Configuration
REQ-016 SHALL, when SRAM_ARB_TURNAROUND_EN is defined, force one idle PHY cycle (ce_n=1, dq_oe=0) between a write PHY cycle and a following read PHY cycle; during that cycle all ch_busy bits of requesting channels are 1 and p is unchanged.
REQ-017 SHALL, without SRAM_ARB_TURNAROUND_EN, insert no idle cycle, so a read may directly follow a write.

Structure
REQ-018 SHALL place in shared package sram_pkg: the read-pipeline entry typedef {valid, ch id of width $clog2(NCH) min 1}, and the NCH/RD_LAT maximum constants.
REQ-019 SHALL implement the round-robin grant as sub-module rr_arbiter (inputs: req vector, pointer; outputs: one-hot grant, grant index, any-grant).

Verification
REQ-020 SHALL cover: ch_en=4'b1111, all reads, held for 8 cycles -> grants in order 0,1,2,3,0,1,2,3 with one grant per cycle.
REQ-021 SHALL cover: ch0 writes addr 0x00010 data 0xA5, then ch2 reads 0x00010 (model SRAM, RD_LAT=2) -> ch_rvalid[2] exactly 3 cycles after acceptance with ch_rdata=0xA5.
REQ-022 SHALL cover: ch1 write directly followed by ch3 read -> one idle PHY cycle with SRAM_ARB_TURNAROUND_EN defined and none without it.
REQ-023 SHALL cover: ch0 read accepted, rst_n pulsed low in the next cycle -> no ch_rvalid after release, sram_ce_n=1 and p=0.
REQ-024 SHALL cover: only ch2 requesting, for 5 cycles -> ch_busy=0 throughout, 5 consecutive PHY cycles, and p=3 afterwards.

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared limits and read-pipeline entry type for the SRAM arbiter
package sram_pkg;

  localparam int NCH_MAX    = 8;
  localparam int RD_LAT_MAX = 4;
  localparam int CH_ID_W    = $clog2(NCH_MAX);

  // Entry id field is sized for the largest channel count so one type fits every build
  typedef struct packed {
    logic               valid;
    logic [CH_ID_W-1:0] ch;
  } rd_ent_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant, search starts at ptr
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_gnt
);

  always_comb begin
    int          k;
    logic [IW-1:0] kk;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      kk = IW'(k);
      if (!any_gnt && req[kk]) begin
        any_gnt  = 1'b1;
        gnt[kk]  = 1'b1;
        gnt_idx  = kk;
      end
    end
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - round-robin multi-channel async SRAM arbiter with registered PHY
// Optional: define SRAM_ARB_TURNAROUND_EN to insert an idle PHY cycle between write and read
module sram_rr_arbiter
  import sram_pkg::*;
#(
  parameter int DW     = 8,
  parameter int AW     = 19,
  parameter int NCH    = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH-1:0]    ch_we,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_wdata,
  output logic [NCH-1:0]    ch_busy,
  output logic [NCH-1:0]    ch_rvalid,
  output logic [DW-1:0]     ch_rdata,
  output logic [AW-1:0]     sram_addr,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic [DW-1:0]     sram_dq_wr,
  output logic              sram_dq_oe,
  input  logic [DW-1:0]     sram_dq_rd
);

  localparam int IW = id_w(NCH);

  logic [IW-1:0]  ptr;
  logic [IW-1:0]  gnt_idx;
  logic [NCH-1:0] arb_gnt;
  logic [NCH-1:0] gnt;
  logic           arb_any;
  logic           stall;
  logic           accept;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic           sel_we;
  logic [NCH-1:0] rv_next;
  rd_ent_t        pipe [RD_LAT];
  rd_ent_t        tail;

  rr_arbiter #(
    .N  (NCH),
    .IW (IW)
  ) u_arb (
    .req     (ch_en),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (arb_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(gnt_idx) == i) begin
        sel_addr  = ch_addr[i*AW +: AW];
        sel_wdata = ch_wdata[i*DW +: DW];
        sel_we    = ch_we[i];
      end
    end
  end

`ifdef SRAM_ARB_TURNAROUND_EN
  // A read winner is held off while the PHY is in a write cycle; pointer stays put
  assign stall = !sram_we_n && arb_any && !sel_we;
`else
  assign stall = 1'b0;
`endif

  assign accept  = arb_any && !stall;
  assign gnt     = stall ? '0 : arb_gnt;
  assign ch_busy = ch_en & ~gnt;
  assign tail    = pipe[RD_LAT-1];

  always_comb begin
    rv_next = '0;
    for (int i = 0; i < NCH; i++) begin
      if (tail.valid && int'(tail.ch) == i) rv_next[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      sram_ce_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
      sram_addr  <= '0;
      sram_dq_wr <= '0;
      ch_rvalid  <= '0;
      ch_rdata   <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      if (accept) ptr <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + IW'(1);
      sram_ce_n  <= !accept;
      sram_we_n  <= !(accept && sel_we);
      sram_oe_n  <= !(accept && !sel_we);
      sram_dq_oe <= accept && sel_we;
      if (accept) sram_addr <= sel_addr;
      if (accept && sel_we) sram_dq_wr <= sel_wdata;
      // Stage k holds the read whose PHY cycle was k cycles ago; the tail samples the pad
      pipe[0] <= '{valid: accept && !sel_we, ch: CH_ID_W'(gnt_idx)};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      ch_rvalid <= rv_next;
      if (tail.valid) ch_rdata <= sram_dq_rd;
    end
  end

endmodule
